seg_digit_scanner: RTL and testbench

SEG_DIGIT_SCANNER -- requirements
Module: seg_digit_scanner

---
 rtl/seg_digit_scanner.sv | 124 ++++++++++++
 tb/tb_seg_digit_scanner.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_digit_scanner.sv
// Multiplexed 4-digit seven-segment scanner: prescaled slots, anti-ghost blanking, frame-latched value.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 always shows).

module seg_digit_lane (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'b0000000;
    case (nib)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      4'hF: seg = 7'b1000111;
      default: seg = 7'b0000000;
    endcase
  end
endmodule

module seg_digit_scanner #(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] value,
  input  logic [3:0]  dp_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  output logic        g,
  output logic        dp,
  output logic [3:0]  an
);
  localparam int NUM_DIG = 4;
  localparam int CW      = $clog2(DIV);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                      state;
  logic [CW-1:0]               cnt;
  logic [1:0]                  dig;
  logic [NUM_DIG-1:0][3:0]     frame_val;
  logic [NUM_DIG-1:0]          frame_dp;
  logic [NUM_DIG-1:0][6:0]     lane_seg;
  logic [NUM_DIG-1:0]          lane_on;
  logic [6:0]                  seg_q;
  logic                        dp_q;
  logic [3:0]                  an_q;
  logic                        tick;

  assign tick = (cnt == CW'(DIV - 1));

  for (genvar i = 0; i < NUM_DIG; i++) begin : g_lane
    seg_digit_lane u_lane (.nib(frame_val[i]), .seg(lane_seg[i]));
`ifdef LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every higher nibble are zero.
    if (i == 0) begin : g_first
      assign lane_on[i] = 1'b1;
    end else begin : g_upper
      assign lane_on[i] = |frame_val[NUM_DIG-1:i];
    end
`else
    assign lane_on[i] = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      dig       <= '0;
      state     <= BLANK;
      frame_val <= '0;
      frame_dp  <= '0;
      an_q      <= 4'b1111;
      seg_q     <= '0;
      dp_q      <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        dig <= dig + 2'd1;
        if (dig == 2'd3) begin
          frame_val <= value;
          frame_dp  <= dp_in;
        end
      end
      // State tracks cnt: BLANK for the first BLANK_CYC counts of every slot.
      if (tick)
        state <= BLANK;
      else if (cnt == CW'(BLANK_CYC - 1))
        state <= SHOW;
      // Outputs reflect the current slot one clock later; blanking separates digits.
      if (state == SHOW && en && lane_on[dig]) begin
        an_q  <= ~(4'b0001 << dig);
        seg_q <= lane_seg[dig];
        dp_q  <= frame_dp[dig];
      end else begin
        an_q  <= 4'b1111;
        seg_q <= '0;
        dp_q  <= 1'b0;
      end
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;
  assign dp = dp_q;
  assign an = an_q;
endmodule

// File: tb/tb_seg_digit_scanner.sv
// Randomized self-checking bench for seg_digit_scanner (DIV=8, BLANK_CYC=2) against a slot-arithmetic model.
module tb_seg_digit_scanner;
  localparam int DIV = 8;
  localparam int BC  = 2;

  logic        clk = 1'b0;
  logic        rst_n, en;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        a, b, c, d, e, f, g, dp;
  logic [3:0]  an;

  seg_digit_scanner #(.DIV(DIV), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .value(value), .dp_in(dp_in),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  logic [6:0] tbl [0:15] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                             7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                             7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                             7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  int          n_chk = 0, n_fail = 0;
  int          n_cyc;          // clocks since reset released
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic [11:0] exp_out;        // {an, a..g, dp}
  wire  [11:0] obs = {an, a, b, c, d, e, f, g, dp};

  function automatic bit digit_lit(int dg);
`ifdef LEADING_ZERO_BLANK_EN
    return dg == 0 || (m_val >> (4 * dg)) != 0;
`else
    return 1'b1;
`endif
  endfunction

  // One clock: the model works from slot position = n_cyc mod DIV, digit = (n_cyc / DIV) mod 4.
  task automatic step();
    int pos, dg;
    @(posedge clk);
    if (!rst_n) begin
      n_cyc = 0; m_val = '0; m_dp = '0; exp_out = {4'hF, 8'h00};
    end else begin
      pos = n_cyc % DIV;
      dg  = (n_cyc / DIV) % 4;
      if (pos >= BC && en && digit_lit(dg)) begin
        exp_out = {~(4'b0001 << dg), tbl[(m_val >> (4 * dg)) & 16'hF], m_dp[dg]};
      end else begin
        exp_out = {4'hF, 8'h00};
      end
      if (pos == DIV - 1 && dg == 3) begin
        m_val = value; m_dp = dp_in;
      end
      n_cyc++;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; value = 16'h0000; dp_in = 4'h0;
    repeat (3) step();
    n_chk++;
    if (obs !== {4'hF, 8'h00}) begin
      n_fail++; $display("FAIL reset_outputs got=%h want=%h", obs, 12'hF00);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_scan();
    int low_cnt [4] = '{0, 0, 0, 0};
    int blank_cnt = 0;
    value = 16'h0000;
    repeat (40) begin
      step();
      n_chk++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL zero_scan got=%h want=%h t=%0d", obs, exp_out, n_cyc);
      end
      n_chk++;
      if ($countones(~an) > 1) begin
        n_fail++; $display("FAIL zero_scan_onehot an=%b want<=1 low", an);
      end
      for (int i = 0; i < 4; i++) if (an == ~(4'b0001 << i) && {a, b, c, d, e, f, g} == 7'b1111110) low_cnt[i]++;
      if (an == 4'hF) blank_cnt++;
    end
    // 40 clocks cover 5 slots: digit 0 appears twice, each slot 6 lit + 2 dark.
    n_chk++;
    if (low_cnt[0] != 12 || low_cnt[1] != 6 || low_cnt[2] != 6 || low_cnt[3] != 6 || blank_cnt != 10) begin
      n_fail++; $display("FAIL zero_scan_counts got=%0d,%0d,%0d,%0d blank=%0d want=12,6,6,6 blank=10",
                         low_cnt[0], low_cnt[1], low_cnt[2], low_cnt[3], blank_cnt);
    end
  endtask

  task automatic test_frame_latch();
    int seen_f = 0;
    value = 16'hF81A;
    repeat (64) begin
      step();
      n_chk++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL frame_latch got=%h want=%h t=%0d", obs, exp_out, n_cyc);
      end
      n_chk++;
      if ($countones(~an) > 1) begin
        n_fail++; $display("FAIL frame_latch_onehot an=%b want<=1 low", an);
      end
      if (an == 4'b0111 && {a, b, c, d, e, f, g} == 7'b1000111) seen_f++;
    end
    n_chk++;
    if (seen_f == 0) begin
      n_fail++; $display("FAIL frame_latch_digit3 got=%0d want>0 cycles showing F", seen_f);
    end
  endtask

  task automatic test_dp_en();
    dp_in = 4'b0100;
    repeat (40) step();
    repeat (50) begin
      step();
      if ((n_cyc % 20) == 5) en = 1'b0;
      if ((n_cyc % 20) == 15) en = 1'b1;
      n_chk++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL dp_en got=%h want=%h t=%0d en=%b", obs, exp_out, n_cyc, en);
      end
      n_chk++;
      if (dp && an != 4'b1011) begin
        n_fail++; $display("FAIL dp_en_digit an=%b want=1011 when dp=1", an);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_mid_reset(int target, logic [15:0] v);
    int budget = 64;
    value = v;
    while ((n_cyc % 32) != target && budget > 0) begin
      step(); budget--;
    end
    n_chk++;
    if (budget == 0) begin
      n_fail++; $display("FAIL mid_reset_align got=%0d want=%0d", n_cyc % 32, target);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_chk++;
    if (obs !== {4'hF, 8'h00}) begin
      n_fail++; $display("FAIL mid_reset_blank got=%h want=%h", obs, 12'hF00);
    end
    repeat (40) begin
      step();
      n_chk++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL mid_reset_run got=%h want=%h t=%0d", obs, exp_out, n_cyc);
      end
    end
  endtask

  task automatic test_leading_zero();
    value = 16'h0050;
    repeat (64) begin
      step();
      n_chk++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL leading_zero got=%h want=%h t=%0d", obs, exp_out, n_cyc);
      end
    end
  endtask

  task automatic test_random();
    repeat (800) begin
      if ($urandom_range(0, 15) == 0) value = 16'($urandom);
      if ($urandom_range(0, 15) == 0) value = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 20) == 0) en = ~en;
      if ($urandom_range(0, 200) == 0) rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      n_chk++;
      if (obs !== exp_out) begin
        n_fail++; $display("FAIL random got=%h want=%h t=%0d", obs, exp_out, n_cyc);
      end
      n_chk++;
      if ($countones(~an) > 1) begin
        n_fail++; $display("FAIL random_onehot an=%b want<=1 low", an);
      end
    end
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_zero_scan();
    test_frame_latch();
    test_dp_en();
    test_mid_reset(20, 16'h3C7B);
    test_mid_reset(31, 16'hABCD);
    test_leading_zero();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
